// File: rtl/llr_pkg.sv
// Shared types and code lookups for the LLR memory sequencer.
package llr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEG,
        ST_ROT,
        ST_DONE
    } state_t;

    localparam logic [1:0] CODE_128  = 2'd0;
    localparam logic [1:0] CODE_256  = 2'd1;
    localparam logic [1:0] CODE_1024 = 2'd2;
    localparam logic [1:0] CODE_ILL  = 2'd3;

    // Index of the final 128-LLR segment for a code.
    function automatic logic [2:0] seg_last(input logic [1:0] code);
        logic [2:0] r;
        r = 3'd7;
        case (code)
            CODE_128: r = 3'd0;
            CODE_256: r = 3'd1;
            default:  r = 3'd7;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/llr_mem_ctrl_if.sv
// Input LLR beat stream: valid/ready handshake with 64b beats.
interface llr_mem_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/llr_mem_ctrl.sv
// Load/segment/rotate sequencer for the 1024x7b LLR memory.
// LLR_MEM_CTRL_PERF_EN adds o_cycles, a start-to-done cycle counter.
module llr_mem_ctrl
    import llr_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int SEG_LEN = 128,
    parameter int BEAT_W  = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_code,
    llr_mem_ctrl_if.slave     in_if,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_rotate,
    output logic [1:0]        o_mem_code,
    output logic              o_seg_start,
    output logic [2:0]        o_seg_idx,
    input  logic              i_seg_done,
    output logic              o_done,
`ifdef LLR_MEM_CTRL_PERF_EN
    output logic              o_err,
    output logic [15:0]       o_cycles
`else
    output logic              o_err
`endif
);

    localparam int LLR_PER_BEAT  = DATA_W / 8;
    localparam int BEATS_PER_SEG = SEG_LEN / LLR_PER_BEAT;

    state_t            state;
    state_t            nxt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_last;
    logic [2:0]        seg_idx;
    logic [1:0]        code_q;
    logic              seg_start_q;
    logic              err_q;
    logic              idle_like;
    logic              start_ok;
    logic              start_bad;
    logic              fire;
    logic              beat_end;
    logic              seg_end;
    logic              seg_adv;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok  = idle_like && i_start && (i_code != CODE_ILL);
    assign start_bad = idle_like && i_start && (i_code == CODE_ILL);

    assign in_if.in_ready = (state == ST_LOAD);
    assign fire           = in_if.in_valid && in_if.in_ready;

    // Total beats follow from the segment count of the latched code.
    assign beat_last = BEAT_W'((int'(seg_last(code_q)) + 1) * BEATS_PER_SEG - 1);
    assign beat_end  = fire && (beat_cnt == beat_last);
    assign seg_end   = (seg_idx == seg_last(code_q));
    assign seg_adv   = (state == ST_ROT) && !seg_end;

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start_ok) nxt = ST_LOAD;
            ST_LOAD:          if (beat_end) nxt = ST_SEG;
            ST_SEG:           if (i_seg_done) nxt = ST_ROT;
            ST_ROT:           nxt = seg_end ? ST_DONE : ST_SEG;
            default:          nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt    <= '0;
            seg_idx     <= '0;
            code_q      <= '0;
            seg_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q       <= start_bad;
            seg_start_q <= ((state == ST_LOAD) && beat_end) || seg_adv;
            if (start_ok) begin
                code_q   <= i_code;
                beat_cnt <= '0;
                seg_idx  <= '0;
            end else begin
                if (fire)    beat_cnt <= beat_cnt + 1'b1;
                if (seg_adv) seg_idx  <= seg_idx + 1'b1;
            end
        end
    end

`ifdef LLR_MEM_CTRL_PERF_EN
    logic [15:0] cyc_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_q <= '0;
        end else if (start_ok) begin
            cyc_q <= '0;
        end else if ((state inside {ST_LOAD, ST_SEG, ST_ROT}) && (cyc_q != 16'hFFFF)) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign o_cycles = cyc_q;
`endif

    assign o_mem_wen    = fire;
    assign o_mem_data   = in_if.in_ready ? in_if.in_data : '0;
    assign o_mem_rotate = (state == ST_ROT);
    assign o_mem_code   = code_q;
    assign o_seg_start  = seg_start_q;
    assign o_seg_idx    = seg_idx;
    assign o_done       = (state == ST_DONE);
    assign o_err        = err_q;

endmodule

// File: tb/tb_llr_mem_ctrl.sv
// Scoreboard bench for llr_mem_ctrl: load, segment and rotate sequencing.
module tb_llr_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [1:0]  i_code;
    logic        i_seg_done;
    logic        o_mem_wen;
    logic [63:0] o_mem_data;
    logic        o_mem_rotate;
    logic [1:0]  o_mem_code;
    logic        o_seg_start;
    logic [2:0]  o_seg_idx;
    logic        o_done;
    logic        o_err;
`ifdef LLR_MEM_CTRL_PERF_EN
    logic [15:0] o_cycles;
`endif

    llr_mem_ctrl_if #(.DATA_W(64)) bus ();

    llr_mem_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_code      (i_code),
        .in_if       (bus.slave),
        .o_mem_wen   (o_mem_wen),
        .o_mem_data  (o_mem_data),
        .o_mem_rotate(o_mem_rotate),
        .o_mem_code  (o_mem_code),
        .o_seg_start (o_seg_start),
        .o_seg_idx   (o_seg_idx),
        .i_seg_done  (i_seg_done),
        .o_done      (o_done),
`ifdef LLR_MEM_CTRL_PERF_EN
        .o_err       (o_err),
        .o_cycles    (o_cycles)
`else
        .o_err       (o_err)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int wen_cnt  = 0;
    int rot_cnt  = 0;
    int ss_cnt   = 0;
    int both_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_mem_wen === 1'b1) begin
            wen_cnt++;
            obs_q.push_back(o_mem_data);
        end
        if (o_mem_rotate === 1'b1) rot_cnt++;
        if (o_seg_start === 1'b1) ss_cnt++;
        if ((o_mem_wen & o_mem_rotate) === 1'b1) both_cnt++;
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        i_start        = 1'b0;
        i_code         = 2'd0;
        i_seg_done     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        #3;
        checks++;
        if ({o_mem_wen, o_mem_rotate, o_seg_start, o_done, o_err, bus.in_ready} !== 6'b0)
            $display("FAIL reset_flags got=%b want=000000",
                     {o_mem_wen, o_mem_rotate, o_seg_start, o_done, o_err, bus.in_ready});
        if ({o_mem_wen, o_mem_rotate, o_seg_start, o_done, o_err, bus.in_ready} !== 6'b0)
            errors++;
        checks++;
        if ({o_mem_data, o_mem_code, o_seg_idx} !== 69'd0) begin
            errors++;
            $display("FAIL reset_values data=%h code=%0d idx=%0d want 0", o_mem_data, o_mem_code, o_seg_idx);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_op(input logic [1:0] c);
        i_code  = c;
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic load(input int n, input bit gaps);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            d = {$urandom, $urandom};
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            exp_q.push_back(d);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic check_sb(input string name);
        logic [63:0] e;
        logic [63:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s missing_write got=none want=%h", name, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s write_data got=%h want=%h", name, o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s extra_writes got=%0d want=0", name, obs_q.size());
        end
    endtask

    // Responds to each o_seg_start; seg_done same cycle or one cycle later.
    task automatic run_segs(input string name, input int segs, input bit same,
                            input logic [1:0] c, output int first_wait);
        bit seen;
        int k;
        first_wait = -1;
        for (int s = 0; s < segs; s++) begin
            seen = 1'b0;
            k = 0;
            while (!seen && k < 300) begin
                @(negedge clk);
                if (o_seg_start === 1'b1) seen = 1'b1;
                else k++;
            end
            if (s == 0) first_wait = k;
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL %s seg_start_timeout seg=%0d got=none want=pulse", name, s);
                return;
            end
            checks++;
            if (o_seg_idx !== 3'(s)) begin
                errors++;
                $display("FAIL %s seg_idx got=%0d want=%0d", name, o_seg_idx, s);
            end
            checks++;
            if (o_mem_code !== c) begin
                errors++;
                $display("FAIL %s mem_code got=%0d want=%0d", name, o_mem_code, c);
            end
            if (!same) begin
                @(posedge clk);
                #1;
            end
            i_seg_done = 1'b1;
            @(posedge clk);
            #1 i_seg_done = 1'b0;
            @(negedge clk);
            checks++;
            if (o_mem_rotate !== 1'b1) begin
                errors++;
                $display("FAIL %s rotate seg=%0d got=%b want=1", name, s, o_mem_rotate);
            end
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done got=%b want=1", name, o_done);
        end
    endtask

    task automatic test_code0();
        int w0, r0, s0, fw;
        do_reset();
        w0 = wen_cnt; r0 = rot_cnt; s0 = ss_cnt;
        start_op(2'd0);
        load(16, 1'b0);
        check_sb("code0");
        run_segs("code0", 1, 1'b0, 2'd0, fw);
        checks++;
        if (fw != 0) begin
            errors++;
            $display("FAIL code0 seg_start_latency got=%0d want=0", fw);
        end
        checks++;
        if (wen_cnt - w0 != 16 || rot_cnt - r0 != 1 || ss_cnt - s0 != 1) begin
            errors++;
            $display("FAIL code0 counts got=%0d/%0d/%0d want=16/1/1",
                     wen_cnt - w0, rot_cnt - r0, ss_cnt - s0);
        end
`ifdef LLR_MEM_CTRL_PERF_EN
        checks++;
        if (o_cycles !== 16'd19) begin
            errors++;
            $display("FAIL perf_cycles got=%0d want=19", o_cycles);
        end
`endif
    endtask

    task automatic test_code2_gaps();
        int w0, r0, s0, fw;
        w0 = wen_cnt; r0 = rot_cnt; s0 = ss_cnt;
        start_op(2'd2);
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL code2 done_clear got=%b want=0", o_done);
        end
        load(128, 1'b1);
        check_sb("code2");
        run_segs("code2", 8, 1'b0, 2'd2, fw);
        checks++;
        if (wen_cnt - w0 != 128 || rot_cnt - r0 != 8 || ss_cnt - s0 != 8) begin
            errors++;
            $display("FAIL code2 counts got=%0d/%0d/%0d want=128/8/8",
                     wen_cnt - w0, rot_cnt - r0, ss_cnt - s0);
        end
    endtask

    task automatic test_code1_same_cycle();
        int r0, fw;
        r0 = rot_cnt;
        start_op(2'd1);
        load(32, 1'b0);
        check_sb("code1");
        run_segs("code1", 2, 1'b1, 2'd1, fw);
        checks++;
        if (rot_cnt - r0 != 2) begin
            errors++;
            $display("FAIL code1 rotates got=%0d want=2", rot_cnt - r0);
        end
    endtask

    task automatic test_illegal();
        int w0;
        do_reset();
        w0 = wen_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hDEAD_BEEF_0000_0001;
        start_op(2'd3);
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal err_pulse got=%b want=1", o_err);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || o_mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL illegal idle got ready=%b wen=%b want 0/0", bus.in_ready, o_mem_wen);
        end
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal err_width got=%b want=0", o_err);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (wen_cnt != w0) begin
            errors++;
            $display("FAIL illegal wen got=%0d want=0", wen_cnt - w0);
        end
    endtask

    task automatic test_ignored_and_reset();
        int fw;
        do_reset();
        start_op(2'd0);
        load(5, 1'b0);
        i_code     = 2'd2;
        i_start    = 1'b1;
        i_seg_done = 1'b1;
        @(posedge clk);
        #1;
        i_start    = 1'b0;
        i_seg_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || o_mem_code !== 2'd0) begin
            errors++;
            $display("FAIL ignored state got ready=%b code=%0d want 1/0", bus.in_ready, o_mem_code);
        end
        @(posedge clk);
        #1;
        load(11, 1'b0);
        check_sb("ignored");
        run_segs("ignored", 1, 1'b0, 2'd0, fw);
        checks++;
        if (fw != 0) begin
            errors++;
            $display("FAIL ignored beat_count seg_start_wait got=%0d want=0", fw);
        end
        start_op(2'd1);
        load(3, 1'b0);
        check_sb("midreset_pre");
        bus.in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, o_mem_wen, o_mem_code, o_done} !== 5'b0) begin
            errors++;
            $display("FAIL midreset outputs got=%b want=00000",
                     {bus.in_ready, o_mem_wen, o_mem_code, o_done});
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_op(2'd0);
        load(16, 1'b0);
        check_sb("restart");
        run_segs("restart", 1, 1'b1, 2'd0, fw);
    endtask

    initial begin
        test_code0();
        test_code2_gaps();
        test_code1_same_cycle();
        test_illegal();
        test_ignored_and_reset();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL wen_rotate_overlap got=%0d want=0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
